// File: rtl/alu_cmd_master.sv
// UART command master: sends operand A, operand B and the opcode, then waits for one result byte.
// Optional response timeout is compiled in with the ALU_CMD_TIMEOUT_EN macro.
module alu_cmd_master #(
  parameter int DATA_BITS      = 8,
  parameter int OPCODE_BITS    = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic [DATA_BITS-1:0]   i_op_a,
  input  logic [DATA_BITS-1:0]   i_op_b,
  input  logic [OPCODE_BITS-1:0] i_op_code,
  input  logic                   i_tx_full,
  input  logic                   i_rx_empty,
  input  logic [DATA_BITS-1:0]   i_r_data,
  output logic                   o_wr_uart,
  output logic [DATA_BITS-1:0]   o_w_data,
  output logic                   o_rd_uart,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [DATA_BITS-1:0]   o_result,
  output logic                   o_timeout
);

  if (OPCODE_BITS > DATA_BITS || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
    $error("alu_cmd_master: illegal parameter combination");
  end

  // IDLE: flush RX / accept start; SEND_*: push one byte each; WAIT_RES: pop result; DONE: 1-cycle pulse
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_A   = 3'd1,
    SEND_B   = 3'd2,
    SEND_OP  = 3'd3,
    WAIT_RES = 3'd4,
    DONE     = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   op_a_q, op_a_d;
  logic [DATA_BITS-1:0]   op_b_q, op_b_d;
  logic [OPCODE_BITS-1:0] op_code_q, op_code_d;
  logic [DATA_BITS-1:0]   result_q, result_d;
  logic                   wr_uart;
  logic                   rd_uart;
  logic [DATA_BITS-1:0]   w_data;
  logic                   timeout_hit;

`ifdef ALU_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  // A result byte arriving on the limit cycle wins over the timeout.
  assign timeout_hit = (state_q == WAIT_RES) && i_rx_empty && (tmo_cnt_q == TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == SEND_OP && wr_uart) begin
      tmo_cnt_d = '0;
    end else if (state_q == WAIT_RES && i_rx_empty && !timeout_hit) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    result_d  = result_q;
    wr_uart   = 1'b0;
    rd_uart   = 1'b0;
    w_data    = '0;
    case (state_q)
      IDLE: begin
        if (!i_rx_empty) begin
          rd_uart = 1'b1;
        end else if (i_start) begin
          op_a_d    = i_op_a;
          op_b_d    = i_op_b;
          op_code_d = i_op_code;
          state_d   = SEND_A;
        end
      end
      SEND_A: begin
        w_data  = op_a_q;
        wr_uart = !i_tx_full;
        if (wr_uart) state_d = SEND_B;
      end
      SEND_B: begin
        w_data  = op_b_q;
        wr_uart = !i_tx_full;
        if (wr_uart) state_d = SEND_OP;
      end
      SEND_OP: begin
        w_data  = DATA_BITS'(op_code_q);
        wr_uart = !i_tx_full;
        if (wr_uart) state_d = WAIT_RES;
      end
      WAIT_RES: begin
        if (!i_rx_empty) begin
          rd_uart  = 1'b1;
          result_d = i_r_data;
          state_d  = DONE;
        end else if (timeout_hit) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      result_q  <= result_d;
    end
  end

  // Reset holds the FSM in IDLE, where a non-empty RX would otherwise request a pop.
  assign o_rd_uart = rd_uart & ~i_reset;
  assign o_wr_uart = wr_uart & ~i_reset;
  assign o_w_data  = w_data;
  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_result  = result_q;
  assign o_timeout = timeout_hit & ~i_reset;

endmodule

// File: tb/tb_alu_cmd_master.sv
// Directed bench for alu_cmd_master; covers the timeout path when ALU_CMD_TIMEOUT_EN is defined.
module tb_alu_cmd_master;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic [7:0] i_op_a;
  logic [7:0] i_op_b;
  logic [5:0] i_op_code;
  logic       i_tx_full;
  logic       i_rx_empty;
  logic [7:0] i_r_data;
  logic       o_wr_uart;
  logic [7:0] o_w_data;
  logic       o_rd_uart;
  logic       o_busy;
  logic       o_done;
  logic [7:0] o_result;
  logic       o_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  alu_cmd_master #(
    .DATA_BITS     (8),
    .OPCODE_BITS   (6),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .i_op_code (i_op_code),
    .i_tx_full (i_tx_full),
    .i_rx_empty(i_rx_empty),
    .i_r_data  (i_r_data),
    .o_wr_uart (o_wr_uart),
    .o_w_data  (o_w_data),
    .o_rd_uart (o_rd_uart),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_result  (o_result),
    .o_timeout (o_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) chk("wr_rd_exclusive", {31'd0, o_wr_uart & o_rd_uart}, 32'd0);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_op_a     = 8'h00;
    i_op_b     = 8'h00;
    i_op_code  = 6'h00;
    i_tx_full  = 1'b0;
    i_rx_empty = 1'b0;
    i_r_data   = 8'hAA;
    #1;
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_rd", o_rd_uart, 0);
    chk("rst_wr", o_wr_uart, 0);
    chk("rst_result", o_result, 0);
    chk("rst_timeout", o_timeout, 0);
    #20;
    tick();
    i_reset    = 1'b0;
    i_rx_empty = 1'b1;

    // basic command, response at cycle 10
    tick();
    i_start = 1'b1; i_op_a = 8'h05; i_op_b = 8'h03; i_op_code = 6'h20;
    #1;
    chk("t1_c0_busy", o_busy, 0);
    chk("t1_c0_wr", o_wr_uart, 0);
    tick(); i_start = 1'b0; #1;
    chk("t1_c1_busy", o_busy, 1);
    chk("t1_c1_wr", o_wr_uart, 1);
    chk("t1_c1_data", o_w_data, 8'h05);
    tick(); #1;
    chk("t1_c2_wr", o_wr_uart, 1);
    chk("t1_c2_data", o_w_data, 8'h03);
    tick(); #1;
    chk("t1_c3_wr", o_wr_uart, 1);
    chk("t1_c3_data", o_w_data, 8'h20);
    for (int c = 4; c <= 9; c++) begin
      tick(); #1;
      chk("t1_wait_wr", o_wr_uart, 0);
      chk("t1_wait_rd", o_rd_uart, 0);
      chk("t1_wait_busy", o_busy, 1);
    end
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h08; #1;
    chk("t1_c10_rd", o_rd_uart, 1);
    chk("t1_c10_done", o_done, 0);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t1_c11_done", o_done, 1);
    chk("t1_c11_result", o_result, 8'h08);
    tick(); #1;
    chk("t1_c12_busy", o_busy, 0);
    chk("t1_c12_done", o_done, 0);
    chk("t1_c12_result", o_result, 8'h08);

    // TX backpressure during cycles 2-5
    tick();
    i_start = 1'b1; i_op_a = 8'h05; i_op_b = 8'h03; i_op_code = 6'h20;
    #1;
    tick(); i_start = 1'b0; #1;
    chk("t2_c1_wr", o_wr_uart, 1);
    chk("t2_c1_data", o_w_data, 8'h05);
    for (int c = 2; c <= 5; c++) begin
      tick(); i_tx_full = 1'b1; #1;
      chk("t2_full_wr", o_wr_uart, 0);
      chk("t2_full_data", o_w_data, 8'h03);
    end
    tick(); i_tx_full = 1'b0; #1;
    chk("t2_c6_wr", o_wr_uart, 1);
    chk("t2_c6_data", o_w_data, 8'h03);
    tick(); #1;
    chk("t2_c7_wr", o_wr_uart, 1);
    chk("t2_c7_data", o_w_data, 8'h20);
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h0C; #1;
    chk("t2_c8_result_hold", o_result, 8'h08);
    chk("t2_c8_rd", o_rd_uart, 1);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t2_c9_done", o_done, 1);
    chk("t2_c9_result", o_result, 8'h0C);
    tick(); #1;
    chk("t2_c10_busy", o_busy, 0);

    // stale RX bytes flushed before start is accepted
    tick();
    i_start = 1'b1; i_op_a = 8'h11; i_op_b = 8'h22; i_op_code = 6'h03;
    i_rx_empty = 1'b0; i_r_data = 8'hAA;
    #1;
    chk("t3_flush1_rd", o_rd_uart, 1);
    chk("t3_flush1_busy", o_busy, 0);
    chk("t3_flush1_result", o_result, 8'h0C);
    tick(); i_r_data = 8'hBB; #1;
    chk("t3_flush2_rd", o_rd_uart, 1);
    chk("t3_flush2_busy", o_busy, 0);
    chk("t3_flush2_result", o_result, 8'h0C);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t3_accept_rd", o_rd_uart, 0);
    chk("t3_accept_busy", o_busy, 0);
    chk("t3_accept_result", o_result, 8'h0C);
    tick(); i_start = 1'b0; #1;
    chk("t3_a_busy", o_busy, 1);
    chk("t3_a_data", o_w_data, 8'h11);
    tick(); #1;
    chk("t3_b_data", o_w_data, 8'h22);
    tick(); #1;
    chk("t3_op_data", o_w_data, 8'h03);
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h77; #1;
    chk("t3_pop_rd", o_rd_uart, 1);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t3_done", o_done, 1);
    chk("t3_result", o_result, 8'h77);
    tick(); #1;
    chk("t3_idle_busy", o_busy, 0);

    // start ignored while busy; held start begins the next command after DONE
    tick();
    i_start = 1'b1; i_op_a = 8'h10; i_op_b = 8'h20; i_op_code = 6'h3F;
    #1;
    tick(); i_start = 1'b0; #1;
    chk("t4_a_data", o_w_data, 8'h10);
    tick(); #1;
    chk("t4_b_data", o_w_data, 8'h20);
    tick(); #1;
    chk("t4_op_data", o_w_data, 8'h3F);
    tick(); #1;
    chk("t4_wait_wr", o_wr_uart, 0);
    tick(); i_start = 1'b1; i_op_a = 8'h99; i_op_b = 8'h99; i_op_code = 6'h00; #1;
    chk("t4_pulse_busy", o_busy, 1);
    chk("t4_pulse_wr", o_wr_uart, 0);
    tick(); i_start = 1'b0; #1;
    chk("t4_after_pulse_busy", o_busy, 1);
    chk("t4_after_pulse_wr", o_wr_uart, 0);
    tick(); i_start = 1'b1; i_op_a = 8'h44; i_op_b = 8'h55; i_op_code = 6'h01; #1;
    chk("t4_held_busy", o_busy, 1);
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h30; #1;
    chk("t4_pop_rd", o_rd_uart, 1);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t4_done", o_done, 1);
    chk("t4_result", o_result, 8'h30);
    chk("t4_done_busy", o_busy, 1);
    tick(); #1;
    chk("t4_idle_busy", o_busy, 0);
    tick(); i_start = 1'b0; #1;
    chk("t4_new_busy", o_busy, 1);
    chk("t4_new_wr", o_wr_uart, 1);
    chk("t4_new_a", o_w_data, 8'h44);
    tick(); #1;
    chk("t4_new_b", o_w_data, 8'h55);
    tick(); #1;
    chk("t4_new_op", o_w_data, 8'h01);
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h99; #1;
    chk("t4_new_rd", o_rd_uart, 1);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t4_new_done", o_done, 1);
    chk("t4_new_result", o_result, 8'h99);
    tick(); #1;
    chk("t4_new_idle", o_busy, 0);

`ifdef ALU_CMD_TIMEOUT_EN
    // no response: timeout exactly 100 WAIT_RES cycles after entry
    tick();
    i_start = 1'b1; i_op_a = 8'h01; i_op_b = 8'h02; i_op_code = 6'h04;
    #1;
    tick(); i_start = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    for (int i = 0; i < 100; i++) begin
      tick(); #1;
      chk("t5_wait_timeout", o_timeout, 0);
      chk("t5_wait_busy", o_busy, 1);
    end
    tick(); #1;
    chk("t5_timeout", o_timeout, 1);
    chk("t5_timeout_result", o_result, 8'h99);
    chk("t5_timeout_rd", o_rd_uart, 0);
    tick(); #1;
    chk("t5_after_busy", o_busy, 0);
    chk("t5_after_timeout", o_timeout, 0);
    chk("t5_after_result", o_result, 8'h99);

    // byte arriving on the limit cycle wins
    tick();
    i_start = 1'b1; i_op_a = 8'h01; i_op_b = 8'h02; i_op_code = 6'h04;
    #1;
    tick(); i_start = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    for (int i = 0; i < 100; i++) begin
      tick(); #1;
    end
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h5A; #1;
    chk("t5_prio_rd", o_rd_uart, 1);
    chk("t5_prio_timeout", o_timeout, 0);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t5_prio_done", o_done, 1);
    chk("t5_prio_result", o_result, 8'h5A);
    tick(); #1;
    chk("t5_prio_idle", o_busy, 0);
`else
    // without the timeout the FSM waits indefinitely
    tick();
    i_start = 1'b1; i_op_a = 8'h01; i_op_b = 8'h02; i_op_code = 6'h04;
    #1;
    tick(); i_start = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    for (int i = 0; i < 200; i++) begin
      tick(); #1;
      chk("t5_wait_timeout", o_timeout, 0);
      chk("t5_wait_busy", o_busy, 1);
    end
    tick(); i_rx_empty = 1'b0; i_r_data = 8'h5A; #1;
    chk("t5_late_rd", o_rd_uart, 1);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t5_late_done", o_done, 1);
    chk("t5_late_result", o_result, 8'h5A);
    tick(); #1;
    chk("t5_late_idle", o_busy, 0);
`endif

    // reset in SEND_B aborts; late result is flushed
    tick();
    i_start = 1'b1; i_op_a = 8'h06; i_op_b = 8'h07; i_op_code = 6'h08;
    #1;
    tick(); i_start = 1'b0; #1;
    tick(); #1;
    chk("t6_sendb_wr", o_wr_uart, 1);
    chk("t6_sendb_data", o_w_data, 8'h07);
    i_reset = 1'b1; i_rx_empty = 1'b0; i_r_data = 8'h08;
    #1;
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_wr", o_wr_uart, 0);
    chk("t6_rst_rd", o_rd_uart, 0);
    chk("t6_rst_result", o_result, 0);
    tick(); i_reset = 1'b0; #1;
    chk("t6_flush_rd", o_rd_uart, 1);
    chk("t6_flush_busy", o_busy, 0);
    chk("t6_flush_result", o_result, 0);
    tick(); i_rx_empty = 1'b1; #1;
    chk("t6_end_rd", o_rd_uart, 0);
    chk("t6_end_busy", o_busy, 0);
    chk("t6_end_result", o_result, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_cmd_master.md
ALU_CMD_MASTER -- requirements
Module: alu_cmd_master

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8: UART byte and ALU operand width.
REQ-002 SHALL have parameter OPCODE_BITS, default 6: ALU opcode width, with OPCODE_BITS <= DATA_BITS.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000: response wait limit in clocks, range 1..65535.
REQ-004 SHALL have port i_clk  in  1  clock; all state changes on the rising edge.
REQ-005 SHALL have port i_reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_start  in  1  level request to issue one ALU command.
REQ-007 SHALL have ports i_op_a, i_op_b  in  DATA_BITS  operands A and B.
REQ-008 SHALL have port i_op_code  in  OPCODE_BITS  ALU opcode.
REQ-009 SHALL have port i_tx_full  in  1  UART TX FIFO full.
REQ-010 SHALL have port i_rx_empty  in  1  UART RX FIFO empty.
REQ-011 SHALL have port i_r_data  in  DATA_BITS  UART RX FIFO head byte, valid while i_rx_empty=0.
REQ-012 SHALL have port o_wr_uart  out  1  TX FIFO push strobe.
REQ-013 SHALL have port o_w_data  out  DATA_BITS  byte to push.
REQ-014 SHALL have port o_rd_uart  out  1  RX FIFO pop strobe.
REQ-015 SHALL have port o_busy  out  1  high in every state except IDLE.
REQ-016 SHALL have port o_done  out  1  one-cycle pulse when a result is captured.
REQ-017 SHALL have port o_result  out  DATA_BITS  last received result, registered.
REQ-018 SHALL have port o_timeout  out  1  one-cycle pulse on response timeout (0 when the feature is compiled out).

Function
REQ-019 SHALL implement FSM states IDLE, SEND_A, SEND_B, SEND_OP, WAIT_RES, DONE.
REQ-020 In IDLE with i_rx_empty=0, the block SHALL assert o_rd_uart and discard the byte (stale flush), one byte per cycle.
REQ-021 In IDLE, i_start=1 with i_rx_empty=1 SHALL be accepted: latch i_op_a, i_op_b and i_op_code, and go to SEND_A at the next edge.
REQ-022 While busy, the block SHALL ignore i_start; the requester holds i_start until o_busy rises.
REQ-023 In SEND_A, SEND_B and SEND_OP, o_wr_uart SHALL equal NOT i_tx_full (combinational).
REQ-024 o_w_data SHALL carry latched A, latched B, and latched opcode zero-extended to DATA_BITS, respectively, in those three states.
REQ-025 The FSM SHALL advance to the next send state only on a cycle with o_wr_uart=1; if i_tx_full=1 it holds with no push.
REQ-026 In WAIT_RES with i_rx_empty=0, the block SHALL assert o_rd_uart, load o_result from i_r_data at that edge, and go to DONE.
REQ-027 DONE SHALL last exactly one cycle with o_done=1, then return to IDLE.
REQ-028 o_wr_uart and o_rd_uart SHALL never be high in the same cycle.
REQ-029 Minimum latency with no backpressure SHALL be: start accepted at cycle 0, pushes at cycles 1-3, WAIT_RES from cycle 4, and o_done one cycle after the pop.
REQ-030 o_result SHALL change only on a WAIT_RES pop and hold its value otherwise.

Reset
REQ-031 i_reset=1 SHALL force IDLE, clear the latched operands, o_result=0 and the timeout counter=0, and drive o_busy, o_done, o_timeout, o_wr_uart and o_rd_uart to 0 (o_rd_uart is 0 while reset is held).
REQ-032 Reset asserted mid-command SHALL abort immediately; bytes already pushed are not recalled, and any late result byte is flushed by REQ-020.

Configuration
REQ-033 Macro ALU_CMD_TIMEOUT_EN defined: a 16-bit counter SHALL clear on entry to WAIT_RES and increment each WAIT_RES cycle with i_rx_empty=1.
REQ-034 With ALU_CMD_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES the block SHALL pulse o_timeout for 1 cycle, leave o_result unchanged, and return to IDLE.
REQ-035 With ALU_CMD_TIMEOUT_EN, a byte available in the same cycle the limit is reached SHALL take priority: pop it and go to DONE, with no timeout.
REQ-036 Macro ALU_CMD_TIMEOUT_EN undefined: there SHALL be no counter, o_timeout SHALL be tied 0, and WAIT_RES SHALL wait indefinitely.

Verification
REQ-037 A=0x05, B=0x03, op=0x20, tx_full=0; responder pushes 0x08 at cycle 10 -> pushes 0x05, 0x03, 0x20 at cycles 1-3; o_done at cycle 11; o_result=0x08.
REQ-038 Same command with i_tx_full=1 during cycles 2-5 -> 0x05 pushed at cycle 1, 0x03 pushed at cycle 6, 0x20 at cycle 7; no o_wr_uart during cycles 2-5.
REQ-039 Two stale bytes 0xAA, 0xBB in RX with i_start held -> two IDLE pops, start accepted on the third cycle, and o_result is never 0xAA or 0xBB.
REQ-040 ALU_CMD_TIMEOUT_EN, TIMEOUT_CYCLES=100, no response -> o_timeout pulse exactly 100 WAIT_RES cycles after entry; o_result holds its previous value; o_busy=0 next cycle.
REQ-041 Reset asserted in SEND_B -> same cycle: o_busy=0, o_wr_uart=0; after release, a late 0x08 in RX is flushed in IDLE and o_result stays 0.
REQ-042 i_start pulsed again during WAIT_RES -> ignored; after o_done, the held i_start starts a new command with new operands.
